// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - TX/RX byte FIFOs between bus registers and the UART core
// TX side drains one byte per UART frame through a four-state handshake FSM.
module uart_fifo_bridge #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    input  logic          clr_status,
    output logic          tx_full,
    output logic          tx_empty,
    output logic          rx_full,
    output logic          rx_empty,
    output logic [AW:0]   tx_count,
    output logic [AW:0]   rx_count,
    output logic          tx_ovf,
    output logic          rx_ovf,
    output logic [7:0]    err_count,
    output logic          uart_transmit,
    output logic [7:0]    uart_tx_byte,
    input  logic          uart_is_transmitting,
    input  logic          uart_sent,
    input  logic          uart_received,
    input  logic [7:0]    uart_rx_byte,
    input  logic          uart_recv_error
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_DRAIN
    } tx_state_t;

    tx_state_t       tx_state;
    logic [7:0]      tx_mem [DEPTH];
    logic [7:0]      rx_mem [DEPTH];
    logic [AW-1:0]   tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic            tx_push, tx_pop, rx_push, rx_pop;

    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign rd_data  = rx_mem[rx_rd_ptr];

    // TX never accepts a push while full, even if the FSM pops that cycle.
    assign tx_pop  = (tx_state == S_IDLE) && !tx_empty;
    assign tx_push = wr_en && !tx_full;
    // RX frees a slot for the incoming byte when the bus pops in the same cycle.
    assign rx_pop  = rd_en && !rx_empty;
    assign rx_push = uart_received && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= wr_data;
        if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + (AW+1)'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - (AW+1)'(1);

            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + (AW+1)'(1);
            else if (!rx_push && rx_pop) rx_count <= rx_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_status) begin
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
            err_count <= 8'h00;
        end else begin
            if (wr_en && !tx_push)         tx_ovf <= 1'b1;
            if (uart_received && !rx_push) rx_ovf <= 1'b1;
            if (uart_recv_error && err_count != 8'hFF) err_count <= err_count + 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state      <= S_IDLE;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (!tx_empty) begin
                        uart_tx_byte  <= tx_mem[tx_rd_ptr];
                        uart_transmit <= 1'b1;
                        tx_state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (uart_is_transmitting) begin
                        uart_transmit <= 1'b0;
                        tx_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (uart_sent) tx_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!uart_is_transmitting) tx_state <= S_IDLE;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - directed self-checking bench for uart_fifo_bridge
module tb_uart_fifo_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       clr_status;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [3:0] tx_count, rx_count;
    logic       tx_ovf, rx_ovf;
    logic [7:0] err_count;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       uart_is_transmitting;
    logic       uart_sent;
    logic       uart_received;
    logic [7:0] uart_rx_byte;
    logic       uart_recv_error;

    int checks = 0;
    int failures = 0;

    uart_fifo_bridge #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data),
        .clr_status(clr_status),
        .tx_full(tx_full), .tx_empty(tx_empty),
        .rx_full(rx_full), .rx_empty(rx_empty),
        .tx_count(tx_count), .rx_count(rx_count),
        .tx_ovf(tx_ovf), .rx_ovf(rx_ovf),
        .err_count(err_count),
        .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
        .uart_is_transmitting(uart_is_transmitting),
        .uart_sent(uart_sent), .uart_received(uart_received),
        .uart_rx_byte(uart_rx_byte), .uart_recv_error(uart_recv_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 0; wr_data = 0; rd_en = 0; clr_status = 0;
        uart_is_transmitting = 0; uart_sent = 0; uart_received = 0;
        uart_rx_byte = 0; uart_recv_error = 0;
        step(); step();
        rst = 1'b0;
        checks++; if ({tx_empty, rx_empty, tx_full, rx_full} !== 4'b1100) begin
            failures++; $display("FAIL reset_flags got=%b exp=1100", {tx_empty, rx_empty, tx_full, rx_full}); end
        checks++; if (tx_count !== 4'd0 || rx_count !== 4'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", tx_count, rx_count); end
        checks++; if ({tx_ovf, rx_ovf} !== 2'b00 || err_count !== 8'h00) begin
            failures++; $display("FAIL reset_status got=%b/%h exp=00/00", {tx_ovf, rx_ovf}, err_count); end
        checks++; if (uart_transmit !== 1'b0 || uart_tx_byte !== 8'h00) begin
            failures++; $display("FAIL reset_uart got=%b/%h exp=0/00", uart_transmit, uart_tx_byte); end
    endtask

    task automatic test_tx_single();
        wr_en = 1; wr_data = 8'hA5;
        step();
        wr_en = 0;
        checks++; if (tx_count !== 4'd1 || uart_transmit !== 1'b0) begin
            failures++; $display("FAIL tx_push got=%0d/%b exp=1/0", tx_count, uart_transmit); end
        step();
        checks++; if (uart_transmit !== 1'b1 || uart_tx_byte !== 8'hA5) begin
            failures++; $display("FAIL tx_launch got=%b/%h exp=1/a5", uart_transmit, uart_tx_byte); end
        checks++; if (tx_empty !== 1'b1 || tx_count !== 4'd0) begin
            failures++; $display("FAIL tx_pop got=%b/%0d exp=1/0", tx_empty, tx_count); end
        step();
        checks++; if (uart_transmit !== 1'b1) begin
            failures++; $display("FAIL tx_hold got=%b exp=1", uart_transmit); end
        uart_is_transmitting = 1;
        step();
        checks++; if (uart_transmit !== 1'b0 || uart_tx_byte !== 8'hA5) begin
            failures++; $display("FAIL tx_drop got=%b/%h exp=0/a5", uart_transmit, uart_tx_byte); end
        uart_sent = 1;
        step();
        uart_sent = 0; uart_is_transmitting = 0;
        step();
        step();
        checks++; if (uart_transmit !== 1'b0) begin
            failures++; $display("FAIL tx_idle_after got=%b exp=0", uart_transmit); end
    endtask

    task automatic test_tx_overflow();
        uart_is_transmitting = 1;
        for (int i = 1; i <= 9; i++) begin
            wr_en = 1; wr_data = 8'h10 + 8'(i);
            step();
        end
        checks++; if (tx_count !== 4'd8 || tx_full !== 1'b1 || tx_ovf !== 1'b0) begin
            failures++; $display("FAIL tx_fill got=%0d/%b/%b exp=8/1/0", tx_count, tx_full, tx_ovf); end
        checks++; if (uart_tx_byte !== 8'h11) begin
            failures++; $display("FAIL tx_first_byte got=%h exp=11", uart_tx_byte); end
        wr_data = 8'h1A;
        step();
        wr_en = 0;
        checks++; if (tx_ovf !== 1'b1 || tx_count !== 4'd8) begin
            failures++; $display("FAIL tx_ovf_set got=%b/%0d exp=1/8", tx_ovf, tx_count); end
        clr_status = 1;
        step();
        clr_status = 0;
        checks++; if (tx_ovf !== 1'b0) begin
            failures++; $display("FAIL tx_ovf_clr got=%b exp=0", tx_ovf); end
    endtask

    task automatic test_reset_busy();
        rst = 1; uart_sent = 1; uart_is_transmitting = 0;
        step();
        rst = 0;
        checks++; if (uart_transmit !== 1'b0 || tx_empty !== 1'b1 || tx_count !== 4'd0) begin
            failures++; $display("FAIL rst_busy got=%b/%b/%0d exp=0/1/0", uart_transmit, tx_empty, tx_count); end
        step();
        uart_sent = 0;
        step();
        checks++; if (uart_transmit !== 1'b0 || uart_tx_byte !== 8'h00) begin
            failures++; $display("FAIL rst_idle got=%b/%h exp=0/00", uart_transmit, uart_tx_byte); end
    endtask

    task automatic test_rx();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            uart_received = 1; uart_rx_byte = vals[i];
            step();
            uart_received = 0;
            if (i == 0) begin
                checks++; if (rx_empty !== 1'b0) begin
                    failures++; $display("FAIL rx_latency got=%b exp=0", rx_empty); end
            end
        end
        checks++; if (rx_count !== 4'd3 || rd_data !== 8'h11) begin
            failures++; $display("FAIL rx_three got=%0d/%h exp=3/11", rx_count, rd_data); end
        rd_en = 1;
        step();
        rd_en = 0;
        checks++; if (rx_count !== 4'd2 || rd_data !== 8'h22) begin
            failures++; $display("FAIL rx_pop got=%0d/%h exp=2/22", rx_count, rd_data); end
        rd_en = 1;
        step(); step();
        step();
        rd_en = 0;
        checks++; if (rx_empty !== 1'b1 || rx_count !== 4'd0) begin
            failures++; $display("FAIL rx_drain_empty got=%b/%0d exp=1/0", rx_empty, rx_count); end
    endtask

    task automatic test_rx_full_pop();
        for (int i = 0; i < 8; i++) begin
            uart_received = 1; uart_rx_byte = 8'h40 + 8'(i);
            step();
        end
        uart_received = 0;
        checks++; if (rx_full !== 1'b1 || rd_data !== 8'h40) begin
            failures++; $display("FAIL rx_full got=%b/%h exp=1/40", rx_full, rd_data); end
        uart_received = 1; uart_rx_byte = 8'h99; rd_en = 1;
        step();
        rd_en = 0;
        checks++; if (rx_count !== 4'd8 || rx_ovf !== 1'b0 || rd_data !== 8'h41) begin
            failures++; $display("FAIL rx_full_pop got=%0d/%b/%h exp=8/0/41", rx_count, rx_ovf, rd_data); end
        uart_rx_byte = 8'h77;
        step();
        uart_received = 0;
        checks++; if (rx_ovf !== 1'b1 || rx_count !== 4'd8) begin
            failures++; $display("FAIL rx_ovf_set got=%b/%0d exp=1/8", rx_ovf, rx_count); end
        clr_status = 1;
        step();
        clr_status = 0;
        checks++; if (rx_ovf !== 1'b0) begin
            failures++; $display("FAIL rx_ovf_clr got=%b exp=0", rx_ovf); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
            exp = (i == 7) ? 8'h99 : 8'h41 + 8'(i);
            checks++; if (rd_data !== exp) begin
                failures++; $display("FAIL rx_order[%0d] got=%h exp=%h", i, rd_data, exp); end
            rd_en = 1;
            step();
            rd_en = 0;
        end
        checks++; if (rx_empty !== 1'b1) begin
            failures++; $display("FAIL rx_final_empty got=%b exp=1", rx_empty); end
    endtask

    task automatic test_err_count();
        uart_recv_error = 1;
        for (int i = 0; i < 5; i++) step();
        checks++; if (err_count !== 8'd5) begin
            failures++; $display("FAIL err_five got=%0d exp=5", err_count); end
        for (int i = 5; i < 300; i++) step();
        checks++; if (err_count !== 8'hFF || rx_count !== 4'd0) begin
            failures++; $display("FAIL err_sat got=%h/%0d exp=ff/0", err_count, rx_count); end
        clr_status = 1;
        step();
        clr_status = 0; uart_recv_error = 0;
        checks++; if (err_count !== 8'h00) begin
            failures++; $display("FAIL err_clr_priority got=%h exp=00", err_count); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_overflow();
        test_reset_busy();
        test_rx();
        test_rx_full_pop();
        test_err_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
